// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle: pipeline-side hazard inputs and controller-side enables, forwarding
// selects, state and event counters.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic [4:0]       rs_ID;
  logic [4:0]       rt_ID;
  logic [4:0]       rs_EX;
  logic [4:0]       rt_EX;
  logic             MemRead_EX;
  logic             branch_taken_EX;
  logic             mem_busy;
  logic             RegWrite_MEM;
  logic             RegWrite_WB;
  logic [4:0]       dest_MEM;
  logic [4:0]       dest_WB;

  logic             PCWrite;
  logic             IF_ID_Write;
  logic             ID_EX_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Bubble;
  logic [1:0]       ForwardA;
  logic [1:0]       ForwardB;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] freeze_cnt;

  modport master (
    output rs_ID, rt_ID, rs_EX, rt_EX, MemRead_EX, branch_taken_EX, mem_busy,
           RegWrite_MEM, RegWrite_WB, dest_MEM, dest_WB,
    input  PCWrite, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Bubble,
           ForwardA, ForwardB, state, stall_cnt, flush_cnt, freeze_cnt
  );

  modport slave (
    input  rs_ID, rt_ID, rs_EX, rt_EX, MemRead_EX, branch_taken_EX, mem_busy,
           RegWrite_MEM, RegWrite_WB, dest_MEM, dest_WB,
    output PCWrite, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Bubble,
           ForwardA, ForwardB, state, stall_cnt, flush_cnt, freeze_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freeze/flush/load-use stall arbitration, EX operand forwarding,
// registered condition state and saturating per-condition event counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz_io
);

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StStall  = 2'b01,
    StFlush  = 2'b10,
    StFreeze = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;
  logic             lu;
  logic             pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble;
  logic [1:0]       fwd_a, fwd_b;

  // MEM stage is younger than WB, so its match wins; register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic rw_mem,
                                         input logic [4:0] d_mem, input logic rw_wb,
                                         input logic [4:0] d_wb);
    if (rw_mem && (d_mem != 5'd0) && (d_mem == src)) return 2'b10;
    if (rw_wb && (d_wb != 5'd0) && (d_wb == src))    return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    lu = hz_io.MemRead_EX && (hz_io.rt_EX != 5'd0) &&
         ((hz_io.rt_EX == hz_io.rs_ID) || (hz_io.rt_EX == hz_io.rt_ID));

    state_d = StRun;
    if (hz_io.mem_busy)             state_d = StFreeze;
    else if (hz_io.branch_taken_EX) state_d = StFlush;
    else if (lu)                    state_d = StStall;

    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    unique case (state_d)
      StFreeze: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_write = 1'b0;
      end
      StFlush: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      StStall: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      default: ;
    endcase

    fwd_a = fwd_sel(hz_io.rs_EX, hz_io.RegWrite_MEM, hz_io.dest_MEM,
                    hz_io.RegWrite_WB, hz_io.dest_WB);
    fwd_b = fwd_sel(hz_io.rt_EX, hz_io.RegWrite_MEM, hz_io.dest_MEM,
                    hz_io.RegWrite_WB, hz_io.dest_WB);

    // Reset holds the pipeline empty: nothing advances and every stage sees a bubble.
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      fwd_a        = 2'b00;
      fwd_b        = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_d)
        StStall:  if (stall_cnt_q != '1)  stall_cnt_q  <= stall_cnt_q + CNT_W'(1);
        StFlush:  if (flush_cnt_q != '1)  flush_cnt_q  <= flush_cnt_q + CNT_W'(1);
        StFreeze: if (freeze_cnt_q != '1) freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign hz_io.PCWrite      = pc_write;
  assign hz_io.IF_ID_Write  = if_id_write;
  assign hz_io.ID_EX_Write  = id_ex_write;
  assign hz_io.IF_ID_Flush  = if_id_flush;
  assign hz_io.ID_EX_Bubble = id_ex_bubble;
  assign hz_io.ForwardA     = fwd_a;
  assign hz_io.ForwardB     = fwd_b;
  assign hz_io.state        = state_q;
  assign hz_io.stall_cnt    = stall_cnt_q;
  assign hz_io.flush_cnt    = flush_cnt_q;
  assign hz_io.freeze_cnt   = freeze_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic against a
// behavioural model; a monitor pops expectations one cycle at a time and compares.
module tb_hazard_ctrl;
  localparam int unsigned CW  = 4;
  localparam int          SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) hz ();
  hazard_ctrl #(.CNT_W(CW)) dut (.clk(clk), .reset(reset), .hz_io(hz));

  typedef struct {
    bit       rst, busy, br, mr, rwm, rww;
    bit [4:0] rsid, rtid, rsex, rtex, dm, dw;
  } stim_t;

  typedef struct {
    bit       pcw, ifw, idw, fl, bub;
    bit [1:0] fa, fb, st;
    int       sc, fc, zc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   m_sc  = 0;
  int   m_fc  = 0;
  int   m_zc  = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic bit [1:0] fwd(input stim_t s, input bit [4:0] src);
    if (s.rwm && s.dm != 0 && s.dm == src) return 2'b10;
    if (s.rww && s.dw != 0 && s.dw == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   lu;
    @(negedge clk);
    reset              = s.rst;
    hz.mem_busy        = s.busy;
    hz.branch_taken_EX = s.br;
    hz.MemRead_EX      = s.mr;
    hz.rs_ID           = s.rsid;
    hz.rt_ID           = s.rtid;
    hz.rs_EX           = s.rsex;
    hz.rt_EX           = s.rtex;
    hz.RegWrite_MEM    = s.rwm;
    hz.RegWrite_WB     = s.rww;
    hz.dest_MEM        = s.dm;
    hz.dest_WB         = s.dw;

    lu = s.mr && s.rtex != 0 && (s.rtex == s.rsid || s.rtex == s.rtid);
    e.fa = fwd(s, s.rsex);
    e.fb = fwd(s, s.rtex);
    if (s.rst) begin
      {e.pcw, e.ifw, e.idw, e.fl, e.bub} = 5'b00011;
      e.fa = 2'b00;
      e.fb = 2'b00;
      e.st = 2'd0;
      m_sc = 0;
      m_fc = 0;
      m_zc = 0;
    end else if (s.busy) begin
      {e.pcw, e.ifw, e.idw, e.fl, e.bub} = 5'b00000;
      e.st = 2'd3;
      m_zc = sat_inc(m_zc);
    end else if (s.br) begin
      {e.pcw, e.ifw, e.idw, e.fl, e.bub} = 5'b11111;
      e.st = 2'd2;
      m_fc = sat_inc(m_fc);
    end else if (lu) begin
      {e.pcw, e.ifw, e.idw, e.fl, e.bub} = 5'b00101;
      e.st = 2'd1;
      m_sc = sat_inc(m_sc);
    end else begin
      {e.pcw, e.ifw, e.idw, e.fl, e.bub} = 5'b11100;
      e.st = 2'd0;
    end
    e.sc = m_sc;
    e.fc = m_fc;
    e.zc = m_zc;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Combinational outputs still reflect the inputs driven at the prior negedge; registered
  // outputs now reflect the edge just taken.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("PCWrite",      32'(hz.PCWrite),      32'(e.pcw));
        chk("IF_ID_Write",  32'(hz.IF_ID_Write),  32'(e.ifw));
        chk("ID_EX_Write",  32'(hz.ID_EX_Write),  32'(e.idw));
        chk("IF_ID_Flush",  32'(hz.IF_ID_Flush),  32'(e.fl));
        chk("ID_EX_Bubble", 32'(hz.ID_EX_Bubble), 32'(e.bub));
        chk("ForwardA",     32'(hz.ForwardA),     32'(e.fa));
        chk("ForwardB",     32'(hz.ForwardB),     32'(e.fb));
        chk("state",        32'(hz.state),        32'(e.st));
        chk("stall_cnt",    32'(hz.stall_cnt),    32'(e.sc));
        chk("flush_cnt",    32'(hz.flush_cnt),    32'(e.fc));
        chk("freeze_cnt",   32'(hz.freeze_cnt),   32'(e.zc));
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    s = idle();
    s.rst = 1'b1;
    apply(s);
    apply(s);

    // Load-use stall, then the pair moves on.
    s = idle(); s.mr = 1; s.rtex = 8; s.rsid = 8;
    apply(s);
    apply(idle());

    // Branch overrides load-use.
    s = idle(); s.rst = 1; apply(s);
    s = idle(); s.mr = 1; s.rtex = 8; s.rsid = 8; s.br = 1;
    apply(s);
    apply(idle());

    // Forwarding priority and register-0 exclusion.
    s = idle(); s.rwm = 1; s.dm = 5; s.rww = 1; s.dw = 5; s.rsex = 5; s.rtex = 5;
    apply(s);
    s.dm = 0;
    apply(s);

    // Load with rt=0 never stalls.
    s = idle(); s.mr = 1; s.rtex = 0; s.rsid = 0; s.rtid = 0;
    apply(s);

    // Freeze for three cycles over a pending load-use, then the stall.
    s = idle(); s.rst = 1; apply(s);
    s = idle(); s.mr = 1; s.rtex = 8; s.rsid = 8; s.busy = 1;
    repeat (3) apply(s);
    s.busy = 0;
    apply(s);

    // Flush counter saturation.
    s = idle(); s.rst = 1; apply(s);
    s = idle(); s.br = 1;
    repeat (20) apply(s);

    // Reset during freeze.
    s = idle(); s.busy = 1; s.mr = 1; s.rtex = 3; s.rtid = 3;
    apply(s);
    apply(s);
    s.rst = 1;
    apply(s);
    apply(idle());

    for (int i = 0; i < 400; i++) begin
      s.rst  = ($urandom_range(0, 39) == 0);
      s.busy = ($urandom_range(0, 4) == 0);
      s.br   = ($urandom_range(0, 5) == 0);
      s.mr   = 1'($urandom_range(0, 1));
      s.rwm  = 1'($urandom_range(0, 1));
      s.rww  = 1'($urandom_range(0, 1));
      s.rsid = 5'($urandom_range(0, 3));
      s.rtid = 5'($urandom_range(0, 3));
      s.rsex = 5'($urandom_range(0, 3));
      s.rtex = 5'($urandom_range(0, 3));
      s.dm   = 5'($urandom_range(0, 3));
      s.dw   = 5'($urandom_range(0, 3));
      apply(s);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide parameter CNT_W, default 16, width of each saturating event counter.
REQ-002 SHALL provide clk  input  1  clock; all state updates occur on its rising edge.
REQ-003 SHALL provide reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide rs_ID, rt_ID  input  5 each  source register fields of the instruction in ID.
REQ-005 SHALL provide rs_EX, rt_EX  input  5 each  source fields held by the ID/EX register.
REQ-006 SHALL provide MemRead_EX  input  1  MSig[1] of the ID/EX register (load in EX).
REQ-007 SHALL provide branch_taken_EX  input  1  taken branch or jump resolved in EX.
REQ-008 SHALL provide mem_busy  input  1  data memory not ready; freezes the whole pipeline.
REQ-009 SHALL provide RegWrite_MEM, RegWrite_WB  input  1 each  WBSig[1] of the EX/MEM and MEM/WB registers.
REQ-010 SHALL provide dest_MEM, dest_WB  input  5 each  destination register in MEM and WB.
REQ-011 SHALL provide PCWrite, IF_ID_Write, ID_EX_Write  output  1 each  pipeline register enables.
REQ-012 SHALL provide IF_ID_Flush  output  1  clear IF/ID at the next edge.
REQ-013 SHALL provide ID_EX_Bubble  output  1  force CtrlSig into ID/EX to 8'h00.
REQ-014 SHALL provide ForwardA, ForwardB  output  2 each  EX operand select: 00 regfile, 10 MEM, 01 WB.
REQ-015 SHALL provide state  output  2  registered FSM state: 00 RUN, 01 STALL, 10 FLUSH, 11 FREEZE.
REQ-016 SHALL provide stall_cnt, flush_cnt, freeze_cnt  output  CNT_W each  saturating event counters.

Function
REQ-017 lu (load-use) SHALL be MemRead_EX & (rt_EX != 0) & (rt_EX == rs_ID | rt_EX == rt_ID).
REQ-018 Control outputs SHALL be combinational from current inputs; priority mem_busy > branch_taken_EX > lu > normal.
REQ-019 mem_busy=1: PCWrite=IF_ID_Write=ID_EX_Write=0, IF_ID_Flush=0, ID_EX_Bubble=0.
REQ-020 Else branch_taken_EX=1: PCWrite=1, IF_ID_Write=1, ID_EX_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1; lu ignored (wrong-path instruction).
REQ-021 Else lu=1: PCWrite=0, IF_ID_Write=0, ID_EX_Write=1, ID_EX_Bubble=1, IF_ID_Flush=0 (exactly one bubble per load-use pair).
REQ-022 Otherwise: all three write enables 1, IF_ID_Flush=0, ID_EX_Bubble=0.
REQ-023 ForwardA SHALL be 10 if RegWrite_MEM & dest_MEM!=0 & dest_MEM==rs_EX; else 01 if RegWrite_WB & dest_WB!=0 & dest_WB==rs_EX; else 00.
REQ-024 ForwardB SHALL follow REQ-023 with rt_EX in place of rs_EX; MEM match overrides WB match.
REQ-025 Forwarding SHALL be evaluated independently of stall, flush and freeze.
REQ-026 Next state SHALL be FREEZE, FLUSH, STALL or RUN per the winning condition of REQ-018, registered each edge.
REQ-027 Each edge, exactly the counter of the winning condition SHALL increment by 1 (freeze_cnt, flush_cnt or stall_cnt); none on normal.
REQ-028 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 A stall SHALL not repeat: the cycle after STALL the load is in MEM, so lu is naturally 0 for the same pair; no extra logic required or permitted to suppress a genuine new lu.
REQ-030 A load with rt=0 SHALL never cause a stall; forwarding SHALL never select register 0.

Reset
REQ-031 While reset=1: state=RUN, all counters 0 at the next edge.
REQ-032 While reset=1: PCWrite=IF_ID_Write=ID_EX_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, ForwardA=ForwardB=00, overriding REQ-018 to REQ-024.
REQ-033 Reset asserted mid-stall or mid-freeze SHALL abandon the event without counting it in that cycle.

Verification
REQ-034 lw $8 in EX (MemRead_EX=1, rt_EX=8), rs_ID=8 -> PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; next cycle state=01, stall_cnt=1.
REQ-035 Same as REQ-034 plus branch_taken_EX=1 -> IF_ID_Flush=1, PCWrite=1, state=10, flush_cnt=1, stall_cnt=0.
REQ-036 RegWrite_MEM=1, dest_MEM=5, RegWrite_WB=1, dest_WB=5, rs_EX=5, rt_EX=5 -> ForwardA=ForwardB=10; dest_MEM=0 -> both 01.
REQ-037 mem_busy=1 for 3 cycles with lu=1 -> all enables 0, freeze_cnt=3, stall_cnt=0; first cycle after release -> stall.
REQ-038 CNT_W=4, 20 consecutive branch_taken_EX cycles -> flush_cnt=15 and holds.
REQ-039 reset pulsed during mem_busy -> outputs per REQ-032, state=00, counters 0 after the edge.
